// File: rtl/uart_rom_loader_if.sv
// Bus bundle for the UART ROM loader: serial input, flush, read port and status.
// slave = loader side, master = controller/host side.
interface uart_rom_loader_if #(
    parameter int ADDR_W = 16
);
    logic              uart_rx;
    logic              rx_clear;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              read_valid;
    logic [ADDR_W-1:0] wr_count;
    logic              byte_strobe;
    logic              frame_err;
    logic              overflow;

    modport slave (
        input  uart_rx, rx_clear, rd_addr,
        output rd_data, read_valid, wr_count,
        output byte_strobe, frame_err, overflow
    );

    modport master (
        output uart_rx, rx_clear, rd_addr,
        input  rd_data, read_valid, wr_count,
        input  byte_strobe, frame_err, overflow
    );
endinterface

// File: rtl/uart_rom_loader.sv
// UART (8N1) receiver that fills a byte buffer sequentially and serves it
// through a registered read port. Ports: clk, rst (async high), bus (slave).
module uart_rom_loader #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int DEPTH  = 24592,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    uart_rom_loader_if.slave    bus
);
    localparam int BIT_TICKS = CLK_HZ / BAUD;
    localparam int CNT_W     = $clog2(BIT_TICKS + 1);
    localparam int MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(BIT_TICKS / 2);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(BIT_TICKS - 1);
    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         shift_q, shift_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_sync_q, rx_sync_d;
    logic [ADDR_W-1:0]  wr_count_q, wr_count_d;
    logic               read_valid_q, read_valid_d;
    logic               strobe_q, strobe_d;
    logic               frame_err_q, frame_err_d;
    logic               overflow_q, overflow_d;
    logic               rd_hit_q, rd_hit_d;
    logic [7:0]         mem_rd_q;

    logic               tick;
    logic               commit;
    logic               ferr_set;
    logic               full;
    logic               do_write;
    logic [MEM_AW-1:0]  wr_idx;
    logic [MEM_AW-1:0]  rd_idx;

    logic [7:0] mem [DEPTH];

    // Two-flop synchronizer on the asynchronous serial line.
    always_comb begin
        rx_meta_d = bus.uart_rx;
        rx_sync_d = rx_meta_q;
    end

    assign tick = (cnt_q == '0);

    // Receive FSM: next state and datapath updates.
    always_comb begin
        state_d  = state_q;
        cnt_d    = tick ? cnt_q : cnt_q - CNT_W'(1);
        idx_d    = idx_q;
        shift_d  = shift_q;
        commit   = 1'b0;
        ferr_set = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    cnt_d   = CNT_HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!rx_sync_q) begin
                        cnt_d   = CNT_FULL;
                        idx_d   = 3'd0;
                        state_d = DATA;
                    end else begin
                        // Line came back high: a glitch, not a start bit.
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    cnt_d   = CNT_FULL;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    commit   = rx_sync_q;
                    ferr_set = !rx_sync_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (bus.rx_clear) begin
            state_d = IDLE;
        end
    end

    assign full     = ({1'b0, wr_count_q} == DEPTH_W);
    assign do_write = commit && !bus.rx_clear && !full;
    assign wr_idx   = wr_count_q[MEM_AW-1:0];
    assign rd_idx   = bus.rd_addr[MEM_AW-1:0];

    // Buffer bookkeeping and status flags; flush overrides a same-cycle commit.
    always_comb begin
        wr_count_d   = wr_count_q;
        frame_err_d  = frame_err_q | ferr_set;
        overflow_d   = overflow_q | (commit && full);
        strobe_d     = do_write;
        rd_hit_d     = ({1'b0, bus.rd_addr} < DEPTH_W);
        if (do_write) begin
            wr_count_d = wr_count_q + ADDR_W'(1);
        end
        if (bus.rx_clear) begin
            wr_count_d  = '0;
            frame_err_d = 1'b0;
            overflow_d  = 1'b0;
        end
        // Registered alongside wr_count so both change on the same edge.
        read_valid_d = ({1'b0, wr_count_d} == DEPTH_W);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            wr_count_q   <= '0;
            read_valid_q <= 1'b0;
            strobe_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            rd_hit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            rx_meta_q    <= rx_meta_d;
            rx_sync_q    <= rx_sync_d;
            wr_count_q   <= wr_count_d;
            read_valid_q <= read_valid_d;
            strobe_q     <= strobe_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            rd_hit_q     <= rd_hit_d;
        end
    end

    // Plain clocked RAM: read sees the pre-write value on address collision.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_idx] <= shift_q;
        end
        mem_rd_q <= mem[rd_idx];
    end

    // Out-of-range reads and the post-reset output are masked to zero.
    assign bus.rd_data     = rd_hit_q ? mem_rd_q : 8'h00;
    assign bus.read_valid  = read_valid_q;
    assign bus.wr_count    = wr_count_q;
    assign bus.byte_strobe = strobe_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.overflow    = overflow_q;
endmodule

// File: tb/tb_uart_rom_loader.sv
// Randomized scoreboard bench for uart_rom_loader against a byte-level model.
// Runs with a shortened bit period and a 16-byte buffer.
module tb_uart_rom_loader;
    localparam int CLK_HZ = 50000000;
    localparam int BAUD   = 1250000;
    localparam int BT     = CLK_HZ / BAUD;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rom_loader_if #(.ADDR_W(ADDR_W)) bus ();

    uart_rom_loader #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .DEPTH(DEPTH),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: byte store, count and sticky flags.
    logic [7:0] m_mem [DEPTH];
    int         m_cnt  = 0;
    logic       m_ferr = 1'b0;
    logic       m_ovf  = 1'b0;
    int         exp_q [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the next expected count.
    always @(posedge clk) begin
        #1;
        if (bus.byte_strobe === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL strobe_unexpected: count %0d", bus.wr_count);
            end else begin
                int e;
                e = exp_q.pop_front();
                chk("strobe_cnt", 32'(bus.wr_count), 32'(e));
                chk("strobe_rv", 32'(bus.read_valid), 32'(e == DEPTH));
            end
        end
    end

    task automatic drive_frame(input logic [7:0] d, input logic stop);
        @(negedge clk);
        bus.uart_rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.uart_rx = d[i];
            repeat (BT) @(negedge clk);
        end
        bus.uart_rx = stop;
        repeat (BT) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (2 * BT) @(negedge clk);
    endtask

    task automatic model_send(input logic [7:0] d, input logic stop);
        if (!stop) begin
            m_ferr = 1'b1;
        end else if (m_cnt < DEPTH) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            exp_q.push_back(m_cnt);
        end else begin
            m_ovf = 1'b1;
        end
        drive_frame(d, stop);
    endtask

    task automatic status_chk();
        chk("wr_count", 32'(bus.wr_count), 32'(m_cnt));
        chk("read_valid", 32'(bus.read_valid), 32'(m_cnt == DEPTH));
        chk("frame_err", 32'(bus.frame_err), 32'(m_ferr));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    endtask

    task automatic read_chk(input int addr, input logic [7:0] exp);
        @(negedge clk);
        bus.rd_addr = ADDR_W'(addr);
        @(posedge clk);
        #1;
        chk($sformatf("rd_data[%0d]", addr), 32'(bus.rd_data), 32'(exp));
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_cnt"}, 32'(bus.wr_count), 32'(0));
        chk({tag, "_rv"}, 32'(bus.read_valid), 32'(0));
        chk({tag, "_strobe"}, 32'(bus.byte_strobe), 32'(0));
        chk({tag, "_ferr"}, 32'(bus.frame_err), 32'(0));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(0));
        chk({tag, "_rd"}, 32'(bus.rd_data), 32'(0));
    endtask

    initial begin
        logic [7:0] hdr [4];
        hdr[0] = 8'h4E;
        hdr[1] = 8'h45;
        hdr[2] = 8'h53;
        hdr[3] = 8'h1A;

        bus.uart_rx  = 1'b1;
        bus.rx_clear = 1'b0;
        bus.rd_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        zero_chk("reset");
        @(negedge clk);
        rst = 1'b0;

        // Idle line: nothing happens.
        repeat (1000) @(negedge clk);
        status_chk();
        chk("idle_strobe", 32'(bus.byte_strobe), 32'(0));

        // Header bytes.
        for (int i = 0; i < 4; i++) model_send(hdr[i], 1'b1);
        status_chk();
        for (int i = 0; i < 4; i++) read_chk(i, m_mem[i]);

        // Bad stop bit, then a good byte.
        model_send(8'hA5, 1'b0);
        status_chk();
        model_send(8'h3C, 1'b1);
        status_chk();
        read_chk(4, m_mem[4]);

        // Short low glitch on an idle line.
        @(negedge clk);
        bus.uart_rx = 1'b0;
        repeat (BT / 4) @(negedge clk);
        bus.uart_rx = 1'b1;
        repeat (3 * BT) @(negedge clk);
        status_chk();

        // Fill the buffer with random bytes.
        while (m_cnt < DEPTH) model_send(8'($urandom), 1'b1);
        status_chk();

        // One byte too many.
        model_send(8'($urandom), 1'b1);
        status_chk();
        for (int i = 0; i < DEPTH; i++) read_chk(i, m_mem[i]);
        read_chk(DEPTH + 4, 8'h00);

        // Flush mid-frame; held until the line is idle again.
        fork
            drive_frame(8'h77, 1'b1);
            begin
                repeat (3 * BT) @(negedge clk);
                bus.rx_clear = 1'b1;
            end
        join
        bus.rx_clear = 1'b0;
        m_cnt  = 0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        @(negedge clk);
        status_chk();
        for (int i = 0; i < 4; i++) read_chk(i, m_mem[i]);

        // Refill a little and raise a flag, then reset mid-frame.
        model_send(8'($urandom), 1'b1);
        model_send(8'($urandom), 1'b1);
        model_send(8'h5A, 1'b0);
        status_chk();
        fork
            drive_frame(8'h81, 1'b1);
            begin
                repeat (4 * BT) @(negedge clk);
                #3;
                rst = 1'b1;
                #1;
                zero_chk("async_rst");
            end
        join
        @(negedge clk);
        rst = 1'b0;
        m_cnt  = 0;
        m_ferr = 1'b0;
        m_ovf  = 1'b0;
        repeat (4) @(negedge clk);
        status_chk();
        read_chk(1, m_mem[1]);

        repeat (4) @(negedge clk);
        chk("pending_strobes", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
